handshake_domain_cross: RTL and testbench

//   Parametrised multi-bit clock-domain crossing: moves WIDTH-bit words from the
//   clk_a domain to the clk_b domain with a toggle req/ack four-phase-free

---
 rtl/handshake_domain_cross.sv | 118 +++++++++++
 tb/tb_handshake_domain_cross.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_domain_cross.sv
// Toggle req/ack clock-domain crossing for a WIDTH-bit word with valid/ready on both sides.
// The source holds the word stable in `hold` while a request is outstanding, so clk_b samples it directly.
module handshake_domain_cross #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             rst,
    input  logic             clk_a,
    input  logic             clk_b,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("handshake_domain_cross: SYNC_STAGES must be >= 2");
        end
    endgenerate

    typedef enum logic { S_IDLE, S_WAIT } src_state_t;
    typedef enum logic { D_IDLE, D_VALID } dst_state_t;

    src_state_t             src_state;
    dst_state_t             dst_state;
    logic                   req_a;
    logic                   ack_b;
    logic [WIDTH-1:0]       hold;
    logic [SYNC_STAGES-1:0] ack_chain_a;
    logic [SYNC_STAGES-1:0] req_chain_b;
    logic                   ack_sync_a;
    logic                   req_sync_b;

    assign ack_sync_a = ack_chain_a[SYNC_STAGES-1];
    assign req_sync_b = req_chain_b[SYNC_STAGES-1];

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            ack_chain_a <= '0;
        end else begin
            ack_chain_a <= {ack_chain_a[SYNC_STAGES-2:0], ack_b};
        end
    end

    // Source side: one outstanding word; the request is complete once the ack parity matches.
    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            src_state <= S_IDLE;
            req_a     <= 1'b0;
            hold      <= '0;
            in_ready  <= 1'b1;
        end else begin
            case (src_state)
                S_IDLE: begin
                    if (in_valid) begin
                        hold      <= in_data;
                        req_a     <= ~req_a;
                        src_state <= S_WAIT;
                        in_ready  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (ack_sync_a == req_a) begin
                        src_state <= S_IDLE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    src_state <= S_IDLE;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            req_chain_b <= '0;
        end else begin
            req_chain_b <= {req_chain_b[SYNC_STAGES-2:0], req_a};
        end
    end

    // Destination side: a parity difference means a new word; ack only after the consumer takes it.
    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            dst_state <= D_IDLE;
            ack_b     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (dst_state)
                D_IDLE: begin
                    if (req_sync_b != ack_b) begin
                        out_data  <= hold;
                        out_valid <= 1'b1;
                        dst_state <= D_VALID;
                    end
                end
                D_VALID: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ack_b     <= req_sync_b;
                        dst_state <= D_IDLE;
                    end
                end
                default: begin
                    dst_state <= D_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_domain_cross.sv
// Scoreboard bench for handshake_domain_cross: accepted words are queued, delivered words are popped in order.
// A second 32-bit, three-stage instance is used for the latency measurement.
`timescale 1ns/1ps
module tb_handshake_domain_cross;

    logic    clk_a = 1'b0;
    logic    clk_b = 1'b0;
    logic    rst   = 1'b1;
    realtime half_a = 5.0;
    realtime half_b = 13.7;

    logic [7:0]  in_data   = 8'h00;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic [31:0] in_data_w   = 32'h0;
    logic        in_valid_w  = 1'b0;
    logic        in_ready_w;
    logic [31:0] out_data_w;
    logic        out_valid_w;
    logic        out_ready_w = 1'b1;

    int          n_checks    = 0;
    int          n_fail      = 0;
    int          rdy_mode    = 1;
    logic [7:0]  exp_q[$];
    logic        was_stalled = 1'b0;
    logic [7:0]  last_data   = 8'h00;

    handshake_domain_cross #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .rst(rst), .clk_a(clk_a), .clk_b(clk_b),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    handshake_domain_cross #(.WIDTH(32), .SYNC_STAGES(3)) dut_w (
        .rst(rst), .clk_a(clk_a), .clk_b(clk_b),
        .in_data(in_data_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .out_data(out_data_w), .out_valid(out_valid_w), .out_ready(out_ready_w)
    );

    initial forever #(half_a) clk_a = ~clk_a;
    initial forever #(half_b) clk_b = ~clk_b;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: bound expired, got no event, expected one", name);
    endtask

    // Reference model: every word accepted on the source side is delivered exactly once, in order.
    initial forever begin
        @(negedge clk_a);
        if (!rst && in_valid && in_ready) exp_q.push_back(in_data);
    end

    initial forever begin
        @(negedge clk_b);
        if (rst) begin
            was_stalled = 1'b0;
        end else begin
            if (was_stalled && out_valid) checkOutput("stall_data_stable", out_data, last_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL spurious_word: got 0x%0h, expected no delivery", out_data);
                end else begin
                    checkOutput("delivered_word", out_data, exp_q.pop_front());
                end
            end
            was_stalled = out_valid && !out_ready;
            last_data   = out_data;
        end
    end

    initial forever begin
        @(posedge clk_b);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic doReset();
        @(posedge clk_a);
        #2;
        rst = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk_b);
        @(negedge clk_a);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitAccept();
        int t;
        for (t = 0; t < 400; t++) begin
            @(negedge clk_a);
            if (in_ready) break;
        end
        if (t == 400) failNow("accept_timeout");
        @(posedge clk_a);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] word);
        @(posedge clk_a);
        #1;
        in_data  = word;
        in_valid = 1'b1;
        waitAccept();
    endtask

    task automatic waitDrain();
        int t;
        for (t = 0; t < 3000; t++) begin
            @(negedge clk_b);
            if (exp_q.size() == 0) break;
        end
        if (t == 3000) failNow("drain_timeout");
        for (t = 0; t < 50; t++) begin
            @(negedge clk_a);
            if (in_ready) break;
        end
        checkOutput("in_ready_returns", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int edges;
        doReset();
        @(negedge clk_a);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_in_ready_w", 64'(in_ready_w), 64'd1);
        checkOutput("reset_out_valid_w", 64'(out_valid_w), 64'd0);
        checkOutput("reset_out_data_w", 64'(out_data_w), 64'd0);

        $display("[TB] single word 0xA5");
        rdy_mode = 1;
        applyStimulus(8'hA5);
        @(negedge clk_a);
        checkOutput("busy_after_accept", 64'(in_ready), 64'd0);
        waitDrain();

        $display("[TB] 256-word stream, clk_a faster then clk_b faster");
        for (int i = 0; i < 256; i++) applyStimulus(8'(i));
        waitDrain();
        half_a = 13.7;
        half_b = 5.0;
        for (int i = 0; i < 256; i++) applyStimulus(8'(i));
        waitDrain();
        half_a = 5.0;
        half_b = 13.7;

        $display("[TB] consumer stall for 50 cycles");
        rdy_mode = 0;
        applyStimulus(8'h11);
        for (t = 0; t < 100; t++) begin
            @(negedge clk_b);
            if (out_valid) break;
        end
        if (t == 100) failNow("stall_valid_timeout");
        @(posedge clk_a);
        #1;
        in_data  = 8'h22;
        in_valid = 1'b1;
        repeat (50) @(negedge clk_b);
        checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
        checkOutput("stall_out_data", 64'(out_data), 64'h11);
        checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        rdy_mode = 1;
        waitAccept();
        waitDrain();

        $display("[TB] in_data changes while busy");
        applyStimulus(8'h5A);
        for (t = 0; t < 200 && !in_ready; t++) begin
            @(posedge clk_a);
            #1;
            in_data = 8'($urandom);
        end
        waitDrain();

        $display("[TB] random data, gaps and backpressure");
        rdy_mode = 2;
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk_a);
            applyStimulus(8'($urandom));
        end
        waitDrain();
        rdy_mode = 1;

        $display("[TB] reset while source waits for ack");
        rdy_mode = 0;
        applyStimulus(8'h77);
        repeat (3) @(negedge clk_a);
        checkOutput("pre_reset_in_ready", 64'(in_ready), 64'd0);
        doReset();
        @(negedge clk_b);
        checkOutput("post_reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);
        rdy_mode = 1;
        repeat (20) @(negedge clk_b);
        applyStimulus(8'h3C);
        waitDrain();

        $display("[TB] 32-bit, three-stage latency");
        @(posedge clk_a);
        #1;
        checkOutput("w_ready_pre", 64'(in_ready_w), 64'd1);
        in_data_w  = 32'hDEADBEEF;
        in_valid_w = 1'b1;
        @(posedge clk_a);
        edges = 0;
        for (t = 0; t < 20; t++) begin
            @(posedge clk_b);
            edges++;
            #1;
            if (out_valid_w) break;
        end
        in_valid_w = 1'b0;
        n_checks++;
        if (t == 20 || edges < 3 || edges > 5) begin
            n_fail++;
            $display("[TB] FAIL w_latency: got %0d clk_b edges, expected 3..5", edges);
        end
        checkOutput("w_out_data", 64'(out_data_w), 64'hDEADBEEF);
        for (t = 0; t < 100; t++) begin
            @(negedge clk_a);
            if (in_ready_w) break;
        end
        checkOutput("w_in_ready_returns", 64'(in_ready_w), 64'd1);
        @(negedge clk_b);
        checkOutput("w_out_valid_clears", 64'(out_valid_w), 64'd0);

        repeat (10) @(negedge clk_b);
        checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
